// File: rtl/alu_unit_pkg.sv
// rtl/alu_unit_pkg.sv - shared opcode, width and FSM state types for alu_unit
package common;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_XOR  = 4'd2,
        OP_OR   = 4'd3,
        OP_AND  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_MUL  = 4'd10
    } alu_op_t;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } alu_state_t;

endpackage

// File: rtl/alu_unit_mul_iter.sv
// rtl/alu_unit_mul_iter.sv - shift-add multiplier, one partial product per cycle (used under ALU_MUL_EN)
module alu_mul_iter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             word,
    input  logic [WIDTH-1:0] ia,
    input  logic [WIDTH-1:0] ib,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             word_q, word_d;
    logic [WIDTH-1:0] step_sum;

    // The final step's sum is exposed combinationally so the result lands on the last step edge.
    assign step_sum = acc_q + (b_q[0] ? a_q : '0);
    assign busy     = busy_q;
    assign done     = busy_q && (cnt_q == CW'(1));
    assign product  = word_q ? WIDTH'($signed(step_sum[31:0])) : step_sum;

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        word_d = word_q;
        if (start) begin
            a_d    = ia;
            b_d    = ib;
            acc_d  = '0;
            cnt_d  = word ? CW'(32) : CW'(WIDTH);
            busy_d = 1'b1;
            word_d = word;
        end else if (busy_q) begin
            acc_d = step_sum;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            word_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - execute-stage ALU with valid/ready handshake and registered result
// ALU_MUL_EN enables the iterative multiplier for opcode 10; otherwise opcode 10 is reserved.
module alu_unit
    import common::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             word,
    input  logic [WIDTH-1:0] ia,
    input  logic [WIDTH-1:0] ib,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int SHW = $clog2(WIDTH);

    alu_op_t          op_e;
    logic             word_en;
    logic             accept;
    logic [WIDTH-1:0] simple_res;
    logic [SHW-1:0]   sh;
    logic [4:0]       shw;
    logic [31:0]      a32, b32, r32;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    assign op_e      = alu_op_t'(op);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign accept    = in_valid && in_ready;

    always_comb begin
        word_en = 1'b0;
        if (WIDTH == 64 && word) begin
            word_en = (op_e inside {OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_SRA, OP_MUL});
        end
    end

    // Full-width and low-word results are formed side by side; word mode picks the sign-extended word.
    always_comb begin
        a32        = ia[31:0];
        b32        = ib[31:0];
        sh         = ib[SHW-1:0];
        shw        = ib[4:0];
        r32        = '0;
        simple_res = '0;
        case (op_e)
            OP_ADD: begin
                simple_res = ia + ib;
                r32        = a32 + b32;
            end
            OP_SUB: begin
                simple_res = ia - ib;
                r32        = a32 - b32;
            end
            OP_XOR:  simple_res = ia ^ ib;
            OP_OR:   simple_res = ia | ib;
            OP_AND:  simple_res = ia & ib;
            OP_SLL: begin
                simple_res = ia << sh;
                r32        = a32 << shw;
            end
            OP_SRL: begin
                simple_res = ia >> sh;
                r32        = a32 >> shw;
            end
            OP_SRA: begin
                simple_res = WIDTH'($signed(ia) >>> sh);
                r32        = 32'($signed(a32) >>> shw);
            end
            OP_SLT:  simple_res = WIDTH'($signed(ia) < $signed(ib));
            OP_SLTU: simple_res = WIDTH'(ia < ib);
            default: simple_res = '0;
        endcase
        if (word_en) begin
            simple_res = WIDTH'($signed(r32));
        end
    end

`ifdef ALU_MUL_EN
    alu_state_t       state_q, state_d;
    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] mul_prod;

    alu_mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk    (clk),
        .reset  (reset),
        .start  (mul_start),
        .word   (word_en),
        .ia     (ia),
        .ib     (ib),
        .busy   (mul_busy),
        .done   (mul_done),
        .product(mul_prod)
    );

    assign in_ready = !reset && (state_q == ST_IDLE) && !mul_busy && (!out_valid_q || out_ready);

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        mul_start   = 1'b0;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (op_e == OP_MUL) begin
                        mul_start = 1'b1;
                        state_d   = ST_MUL_BUSY;
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = simple_res;
                    end
                end
            end
            ST_MUL_BUSY: begin
                if (mul_done) begin
                    out_valid_d = 1'b1;
                    out_data_d  = mul_prod;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end
`else
    assign in_ready = !reset && (!out_valid_q || out_ready);

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = simple_res;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// tb/tb_alu_unit.sv - scoreboard bench for alu_unit (WIDTH=64), follows ALU_MUL_EN like the design
module tb_alu_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic        word;
    logic [63:0] ia;
    logic [63:0] ib;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;

    int          vectors = 0;
    int          miscompares = 0;
    int          ready_mode = 1;
    logic [63:0] exp_q[$];

    alu_unit #(.WIDTH(64)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .word     (word),
        .ia       (ia),
        .ib       (ib),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    function automatic logic [63:0] model(input logic [3:0] o, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
        int          sh;
        int          sw;
        logic [31:0] a32;
        logic [31:0] b32;
        logic [31:0] t;
        logic        wm;
        sh  = int'(b[5:0]);
        sw  = int'(b[4:0]);
        a32 = a[31:0];
        b32 = b[31:0];
        wm  = w && (o == 0 || o == 1 || o == 5 || o == 6 || o == 7 || o == 10);
        case (o)
            4'd0: begin t = a32 + b32; return wm ? sx32(t) : a + b; end
            4'd1: begin t = a32 - b32; return wm ? sx32(t) : a - b; end
            4'd2: return a ^ b;
            4'd3: return a | b;
            4'd4: return a & b;
            4'd5: begin t = a32 << sw; return wm ? sx32(t) : a << sh; end
            4'd6: begin t = a32 >> sw; return wm ? sx32(t) : a >> sh; end
            4'd7: begin
                t = a32[31] ? ~((~a32) >> sw) : a32 >> sw;
                if (wm) return sx32(t);
                return a[63] ? ~((~a) >> sh) : a >> sh;
            end
            4'd8: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'd9: return (a < b) ? 64'd1 : 64'd0;
`ifdef ALU_MUL_EN
            4'd10: begin t = a32 * b32; return wm ? sx32(t) : a * b; end
`endif
            default: return 64'd0;
        endcase
    endfunction

    // Offer one operation; the expected result is queued on the edge it is accepted.
    task automatic issue(input logic [3:0] o, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        op = o;
        word = w;
        ia = a;
        ib = b;
        forever begin
            #4;
            if (in_ready) begin
                exp_q.push_back(exp);
                @(posedge clk);
                break;
            end
            n++;
            if (n > 300) begin
                chk("accept_timeout", 64'(in_ready), 64'd1);
                break;
            end
            @(negedge clk);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        ready_mode = 1;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    // Counts edges after the accept edge until out_valid is seen.
    task automatic lat_check(input string name, input logic [3:0] o, input logic w,
                             input logic [63:0] a, input logic [63:0] b,
                             input logic [63:0] exp, input int lat);
        int m;
        drain();
        issue(o, w, a, b, exp);
        m = 0;
        forever begin
            @(negedge clk);
            #4;
            if (out_valid || m > 200) break;
            m++;
        end
        chk(name, 64'(m), 64'(lat));
    endtask

    initial begin : ready_driver
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (ready_mode)
                1:       out_ready = 1'b1;
                2:       out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    initial begin : monitor
        logic        prev_hold;
        logic [63:0] prev_d;
        prev_hold = 1'b0;
        prev_d = '0;
        forever begin
            @(negedge clk);
            #4;
            if (reset) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    chk("hold_valid", 64'(out_valid), 64'd1);
                    chk("hold_data", out_data, prev_d);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) chk("spurious_result", out_data, 64'hx);
                    else chk("result", out_data, exp_q.pop_front());
                end
                prev_hold = out_valid && !out_ready;
                prev_d = out_data;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stimulus
        logic [3:0]  o;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        reset = 1'b1;
        in_valid = 1'b0;
        op = '0;
        word = 1'b0;
        ia = '0;
        ib = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_data", out_data, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        lat_check("add_wrap", 4'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 0);
        lat_check("addw_wrap", 4'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 0);
        lat_check("sra_mask", 4'd7, 1'b0, 64'h8000_0000_0000_0000, 64'h41, 64'hC000_0000_0000_0000, 0);
        lat_check("srlw", 4'd6, 1'b1, 64'h8000_0000, 64'd4, 64'h0000_0000_0800_0000, 0);
        lat_check("sraw", 4'd7, 1'b1, 64'h8000_0000, 64'd4, 64'hFFFF_FFFF_F800_0000, 0);
        lat_check("slt", 4'd8, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 0);
        lat_check("sltu", 4'd9, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 0);
        lat_check("op13", 4'd13, 1'b0, 64'h1234, 64'h5678, 64'd0, 0);
`ifdef ALU_MUL_EN
        lat_check("mul_lat", 4'd10, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 64);
        lat_check("mulw_lat", 4'd10, 1'b1, 64'h10000, 64'h10000, 64'd0, 32);
`else
        lat_check("op10_reserved", 4'd10, 1'b0, 64'd7, 64'd3, 64'd0, 0);
`endif

        // Stalled output: the second ADD must wait and the first result must hold.
        drain();
        ready_mode = 2;
        issue(4'd0, 1'b0, 64'd1, 64'd1, 64'd2);
        @(negedge clk);
        in_valid = 1'b1;
        op = 4'd0;
        word = 1'b0;
        ia = 64'd3;
        ib = 64'd4;
        repeat (3) begin
            #4;
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_data", out_data, 64'd2);
            @(negedge clk);
        end
        ready_mode = 1;
        issue(4'd0, 1'b0, 64'd3, 64'd4, 64'd7);
        drain();

        // Reset with work in flight drops it and leaves the unit usable.
        ready_mode = 2;
`ifdef ALU_MUL_EN
        issue(4'd10, 1'b0, 64'd5, 64'd9, 64'd45);
`else
        issue(4'd0, 1'b0, 64'd5, 64'd9, 64'd14);
`endif
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_out_data", out_data, 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        lat_check("add_after_reset", 4'd0, 1'b0, 64'd2, 64'd3, 64'd5, 0);

        ready_mode = 0;
        for (int i = 0; i < 300; i++) begin
            o = 4'($urandom_range(0, 15));
            w = 1'($urandom_range(0, 1));
            a = {$urandom(), $urandom()};
            b = {$urandom(), $urandom()};
            case ($urandom_range(0, 7))
                0: a = 64'hFFFF_FFFF_FFFF_FFFF;
                1: b = 64'h8000_0000_0000_0000;
                2: a = 64'h0000_0000_8000_0000;
                3: b = 64'(b[6:0]);
                default: ;
            endcase
            issue(o, w, a, b, model(o, w, a, b));
        end
        drain();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
